opt_serial_rx: RTL

- Serial line receiver: the far end of a single-wire option-selected output line, whose idle level is fixed by the OPT generate choice.
- Recovers start/data/stop frames from one asynchronous input and presents parallel bytes with a one-cycle valid strobe.
- Sits between a pad-level serial input and the core.
- Line polarity is chosen at elaboration by an OPT generate branch, matching the transmitter's OPT setting.

---
 rtl/opt_serial_rx.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/opt_serial_rx.sv
// opt_serial_rx: asynchronous serial frame receiver (start, DATA_W data bits LSB first,
// optional even parity, one stop bit). Line polarity is selected by OPT at elaboration.
// Optional feature macro: OPT_SERIAL_RX_PARITY_EN adds an even-parity bit after the data
// bits and makes parity_err live; without it parity_err is tied low.
module opt_serial_rx #(
    parameter int unsigned OPT          = 1,
    parameter int unsigned DATA_W       = 8,
    parameter int unsigned CLKS_PER_BIT = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rx,
    output logic [DATA_W-1:0] data,
    output logic              valid,
    output logic              frame_err,
    output logic              parity_err
);

    localparam int unsigned CntW = $clog2(CLKS_PER_BIT);
    localparam int unsigned IdxW = $clog2(DATA_W);
    localparam logic [CntW-1:0] HalfLoad = CntW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CntW-1:0] FullLoad = CntW'(CLKS_PER_BIT - 1);
    localparam logic [IdxW-1:0] LastIdx  = IdxW'(DATA_W - 1);
    localparam logic [1:0]      SyncIdle = (OPT == 1) ? 2'b11 : 2'b00;

    if (CLKS_PER_BIT < 4) begin : gen_bad_cpb
        $error("opt_serial_rx: CLKS_PER_BIT must be at least 4");
    end
    if (DATA_W < 5 || DATA_W > 16) begin : gen_bad_width
        $error("opt_serial_rx: DATA_W must be in 5..16");
    end

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
`ifdef OPT_SERIAL_RX_PARITY_EN
        StParity,
`endif
        StStop
    } state_e;

    logic [1:0]        rs;
    logic              b;
    state_e            state_q;
    logic [CntW-1:0]   cnt_q;
    logic [IdxW-1:0]   idx_q;
    logic [DATA_W-1:0] shreg_q;
    logic [DATA_W-1:0] data_q;
    logic              seen_idle_q;
    logic              valid_q;
    logic              frame_err_q;

    // Two-flop synchronizer on the raw line, reset to the idle level
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rs <= SyncIdle;
        end else begin
            rs <= {rs[0], rx};
        end
    end

    // Normalise polarity so everything below sees idle = 1, start = 0
    if (OPT == 1) begin : gen_pol_true
        assign b = rs[1];
    end else begin : gen_pol_inv
        assign b = ~rs[1];
    end

`ifdef OPT_SERIAL_RX_PARITY_EN
    logic par_bad_q;
    logic parity_err_q;
`endif

    // Frame FSM with mid-bit sampling; all output pulses registered
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            idx_q       <= '0;
            shreg_q     <= '0;
            data_q      <= '0;
            seen_idle_q <= 1'b1;
            valid_q     <= 1'b0;
            frame_err_q <= 1'b0;
`ifdef OPT_SERIAL_RX_PARITY_EN
            par_bad_q    <= 1'b0;
            parity_err_q <= 1'b0;
`endif
        end else begin
            valid_q     <= 1'b0;
            frame_err_q <= 1'b0;
`ifdef OPT_SERIAL_RX_PARITY_EN
            parity_err_q <= 1'b0;
`endif
            case (state_q)
                StIdle: begin
                    // A start edge only counts after the line has been seen idle,
                    // so a held break reports a single frame error
                    if (b) begin
                        seen_idle_q <= 1'b1;
                    end else if (seen_idle_q) begin
                        cnt_q   <= HalfLoad;
                        state_q <= StStart;
                    end
                end
                StStart: begin
                    if (cnt_q != '0) begin
                        cnt_q <= cnt_q - 1'b1;
                    end else if (b) begin
                        state_q <= StIdle;
                    end else begin
                        cnt_q   <= FullLoad;
                        idx_q   <= '0;
                        state_q <= StData;
                    end
                end
                StData: begin
                    if (cnt_q != '0) begin
                        cnt_q <= cnt_q - 1'b1;
                    end else begin
                        shreg_q[idx_q] <= b;
                        cnt_q          <= FullLoad;
                        idx_q          <= idx_q + 1'b1;
                        if (idx_q == LastIdx) begin
`ifdef OPT_SERIAL_RX_PARITY_EN
                            state_q <= StParity;
`else
                            state_q <= StStop;
`endif
                        end
                    end
                end
`ifdef OPT_SERIAL_RX_PARITY_EN
                StParity: begin
                    if (cnt_q != '0) begin
                        cnt_q <= cnt_q - 1'b1;
                    end else begin
                        // Even parity: data ones plus parity bit must be even
                        par_bad_q <= b ^ (^shreg_q);
                        cnt_q     <= FullLoad;
                        state_q   <= StStop;
                    end
                end
`endif
                StStop: begin
                    if (cnt_q != '0) begin
                        cnt_q <= cnt_q - 1'b1;
                    end else begin
                        // Leave mid stop bit so a back-to-back start is not missed
                        data_q      <= shreg_q;
                        seen_idle_q <= b;
                        state_q     <= StIdle;
                        if (!b) begin
                            frame_err_q <= 1'b1;
`ifdef OPT_SERIAL_RX_PARITY_EN
                        end else if (par_bad_q) begin
                            parity_err_q <= 1'b1;
`endif
                        end else begin
                            valid_q <= 1'b1;
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign data      = data_q;
    assign valid     = valid_q;
    assign frame_err = frame_err_q;
`ifdef OPT_SERIAL_RX_PARITY_EN
    assign parity_err = parity_err_q;
`else
    assign parity_err = 1'b0;
`endif

endmodule
